// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer: one valid/ready input steered by sel into a
// one-entry output register on channel a or b. Optional counters via DEMUX_COUNT_EN.
module demux1x2_reg #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] d,
    input  logic                 sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] a,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [DATAWIDTH-1:0] b,
    output logic                 b_valid,
    input  logic                 b_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]          cnt_a,
    output logic [15:0]          cnt_b
`endif
);

    logic can_a;
    logic can_b;
    logic load_a;
    logic load_b;
    logic drain_a;
    logic drain_b;

    // A channel can take a word when empty or when its current word leaves this cycle.
    assign can_a    = !a_valid || a_ready;
    assign can_b    = !b_valid || b_ready;
    assign in_ready = sel ? can_a : can_b;

    assign load_a   = in_valid && sel && can_a;
    assign load_b   = in_valid && !sel && can_b;
    assign drain_a  = a_valid && a_ready;
    assign drain_b  = b_valid && b_ready;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a       <= '0;
            a_valid <= 1'b0;
        end else if (load_a) begin
            a       <= d;
            a_valid <= 1'b1;
        end else if (drain_a) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            b       <= '0;
            b_valid <= 1'b0;
        end else if (load_b) begin
            b       <= d;
            b_valid <= 1'b1;
        end else if (drain_b) begin
            b_valid <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Counters wrap naturally at 16 bits.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (drain_a) cnt_a <= cnt_a + 16'd1;
            if (drain_b) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_reg.sv
// Self-checking bench for demux1x2_reg: vector table, hand-written corner
// sequences, and randomized traffic against a queue-based channel model.
module tb_demux1x2_reg;

    localparam int DW = 64;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DW-1:0] d = '0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic [DW-1:0] b;
    logic          b_valid;
    logic          b_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [15:0]   cnt_a;
    logic [15:0]   cnt_b;
`endif

    demux1x2_reg #(.DATAWIDTH(DW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .d        (d),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b        (b),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: each channel is a capacity-1 queue of words in flight,
    // plus the last word written (the register keeps it after a drain).
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] last_a, last_b;
    int            xfer_a, xfer_b;
    logic          obs_ir;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        xfer_a = 0;
        xfer_b = 0;
    endtask

    function automatic logic model_ready(input logic s, input logic ar, input logic br);
        if (s) return (qa.size() == 0) || ar;
        return (qb.size() == 0) || br;
    endfunction

    task automatic model_edge(input logic iv, input logic s, input logic [DW-1:0] dd,
                              input logic ar, input logic br);
        logic acc;
        acc = iv && model_ready(s, ar, br);
        if (qa.size() != 0 && ar) begin void'(qa.pop_front()); xfer_a++; end
        if (qb.size() != 0 && br) begin void'(qb.pop_front()); xfer_b++; end
        if (acc && s)  begin qa.push_back(dd); last_a = dd; end
        if (acc && !s) begin qb.push_back(dd); last_b = dd; end
    endtask

    // One clock cycle: drive after the falling edge, check ready before the
    // rising edge, advance the model at the edge, check registers just after.
    task automatic cycle(input logic iv, input logic s, input logic [DW-1:0] dd,
                         input logic ar, input logic br);
        @(negedge Clk);
        in_valid = iv; sel = s; d = dd; a_ready = ar; b_ready = br;
        #1;
        obs_ir = in_ready;
        check("in_ready", DW'(in_ready), DW'(model_ready(s, ar, br)));
        @(posedge Clk);
        model_edge(iv, s, dd, ar, br);
        #1;
        check("a_valid", DW'(a_valid), DW'(qa.size() != 0));
        check("a", a, last_a);
        check("b_valid", DW'(b_valid), DW'(qb.size() != 0));
        check("b", b, last_b);
    endtask

    typedef struct {
        logic          iv, s, ar, br;
        logic [DW-1:0] dd;
        logic          e_ir, e_av, e_bv;
        logic [DW-1:0] e_a, e_b;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Basic routing, stall, routing to B, drain, then streaming alternation.
        vecs[0] = '{1,1,0,0, 64'h1234, 1, 1,0, 64'h1234, 64'h0};
        vecs[1] = '{1,1,0,0, 64'h5555, 0, 1,0, 64'h1234, 64'h0};
        vecs[2] = '{1,0,0,0, 64'h77,   1, 1,1, 64'h1234, 64'h77};
        vecs[3] = '{0,0,1,1, 64'h0,    1, 0,0, 64'h1234, 64'h77};
        vecs[4] = '{1,1,1,1, 64'd1,    1, 1,0, 64'd1,    64'h77};
        vecs[5] = '{1,0,1,1, 64'd2,    1, 0,1, 64'd1,    64'd2};
        vecs[6] = '{1,1,1,1, 64'd3,    1, 1,0, 64'd3,    64'd2};
        vecs[7] = '{1,0,1,1, 64'd4,    1, 0,1, 64'd3,    64'd4};

        model_reset();
        #1;
        check("reset_a_valid", DW'(a_valid), '0);
        check("reset_b_valid", DW'(b_valid), '0);
        check("reset_ready", DW'(in_ready), 64'd1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            in_valid = vecs[i].iv; sel = vecs[i].s; d = vecs[i].dd;
            a_ready = vecs[i].ar; b_ready = vecs[i].br;
            #1;
            check($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
            @(posedge Clk);
            model_edge(vecs[i].iv, vecs[i].s, vecs[i].dd, vecs[i].ar, vecs[i].br);
            #1;
            check($sformatf("vec%0d_a_valid", i), DW'(a_valid), DW'(vecs[i].e_av));
            check($sformatf("vec%0d_a", i), a, vecs[i].e_a);
            check($sformatf("vec%0d_b_valid", i), DW'(b_valid), DW'(vecs[i].e_bv));
            check($sformatf("vec%0d_b", i), b, vecs[i].e_b);
        end

        // Backpressure: A full and held for 10 cycles, then released.
        cycle(1, 1, 64'h1234, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 64'hBEEF, 0, 1);
            check("bp_stall_ready", DW'(obs_ir), '0);
            check("bp_hold_a", a, 64'h1234);
        end
        cycle(1, 1, 64'hBEEF, 1, 1);
        check("bp_release_ready", DW'(obs_ir), 64'd1);
        check("bp_new_a", a, 64'hBEEF);
        check("bp_new_a_valid", DW'(a_valid), 64'd1);

        // Stall on B, then switch sel to the free channel A.
        cycle(1, 0, 64'hB0B, 1, 0);
        cycle(1, 0, 64'hCAFE, 1, 0);
        check("other_stall_ready", DW'(obs_ir), '0);
        cycle(1, 1, 64'hCAFE, 1, 0);
        check("other_switch_ready", DW'(obs_ir), 64'd1);
        check("other_a", a, 64'hCAFE);
        check("other_b_kept", b, 64'hB0B);
        check("other_b_valid", DW'(b_valid), 64'd1);

        // Reset mid-operation with both channels full.
        cycle(1, 1, 64'hAAAA, 0, 0);
        check("pre_rst_full", DW'({a_valid, b_valid}), 64'd3);
        @(negedge Clk);
        in_valid = 1'b0;
        #2 Rst = 1'b1;
        #1;
        check("async_rst_a", a, '0);
        check("async_rst_b", b, '0);
        check("async_rst_valids", DW'({a_valid, b_valid}), '0);
        check("rst_ready", DW'(in_ready), 64'd1);
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        cycle(0, 1, 64'h0, 0, 0);
        check("post_rst_ready", DW'(obs_ir), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

`ifdef DEMUX_COUNT_EN
        check("rand_cnt_a", DW'(cnt_a), DW'(16'(xfer_a)));
        check("rand_cnt_b", DW'(cnt_b), DW'(16'(xfer_b)));
        // Wrap: 65537 A transfers from reset leave cnt_a at 1.
        @(negedge Clk);
        in_valid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        in_valid = 1'b1; sel = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            d = DW'(i);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        @(negedge Clk);
        check("wrap_cnt_a", DW'(cnt_a), 64'd1);
        check("wrap_cnt_b", DW'(cnt_b), '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
